// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one up-counter between NREQ requesters.
// A round-robin pick chooses the owner, the counter runs 0..LEN of that
// owner, and a one-cycle DONE pulse is returned when the interval ends.
module timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] LEN,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       DONE,
    output logic [WIDTH-1:0]      Q,
    output logic                  BUSY
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    cand;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic [WIDTH-1:0] win_len;
    logic [PW-1:0]    ptr_after_sel;
    logic [NREQ-1:0]  sel_onehot;

    // Rotating-priority search: first pending requester at or after ptr_q.
    always_comb begin
        cand      = '0;
        win_idx   = ptr_q;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Pick the winner's terminal count out of the packed LEN bus.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                win_len = LEN[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_after_sel = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);
    assign sel_onehot    = {{(NREQ-1){1'b0}}, 1'b1} << sel_q;

    // Next-state logic: grant from IDLE, abort/finish/count in RUN, clear in FIN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    len_d   = win_len;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!REQ[sel_q]) begin
                    cnt_d   = '0;
                    ptr_d   = ptr_after_sel;
                    state_d = IDLE;
                end else if (cnt_q == len_q) begin
                    ptr_d   = ptr_after_sel;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            FIN: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any run in progress without a DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        GNT  = '0;
        DONE = '0;
        BUSY = 1'b0;
        if (state_q == RUN) begin
            GNT  = sel_onehot;
            BUSY = 1'b1;
        end
        if (state_q == FIN) begin
            DONE = sel_onehot;
        end
    end

    assign Q = cnt_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed vectors with literal expectations plus an
// owner/count model of the arbiter that is compared every cycle.
module tb_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [NREQ-1:0]       REQ = '0;
    logic [NREQ*WIDTH-1:0] LEN = '0;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       DONE;
    logic [WIDTH-1:0]      Q;
    logic                  BUSY;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .LEN  (LEN),
        .GNT  (GNT),
        .DONE (DONE),
        .Q    (Q),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    // Model state: who owns the counter, who is being told it is done, etc.
    int m_owner = -1;
    int m_fin   = -1;
    int m_count = 0;
    int m_len   = 0;
    int m_ptr   = 0;

    function automatic logic reqBit(input logic [NREQ-1:0] req, input int idx);
        logic [NREQ-1:0] s;
        s = req >> idx;
        return s[0];
    endfunction

    function automatic int pickWinner(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (reqBit(req, (ptr + k) % NREQ)) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int getLen(input logic [NREQ*WIDTH-1:0] v, input int w);
        logic [NREQ*WIDTH-1:0] s;
        s = v >> (w * WIDTH);
        return int'(s[WIDTH-1:0]);
    endfunction

    // Reference behaviour: an interval owner counts up to its sampled length.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner <= -1;
            m_fin   <= -1;
            m_count <= 0;
            m_len   <= 0;
            m_ptr   <= 0;
        end else if (m_fin >= 0) begin
            m_fin   <= -1;
            m_count <= 0;
        end else if (m_owner >= 0) begin
            if (!reqBit(REQ, m_owner)) begin
                m_ptr   <= (m_owner + 1) % NREQ;
                m_owner <= -1;
                m_count <= 0;
            end else if (m_count == m_len) begin
                m_fin   <= m_owner;
                m_ptr   <= (m_owner + 1) % NREQ;
                m_owner <= -1;
            end else begin
                m_count <= m_count + 1;
            end
        end else if (REQ != '0) begin
            m_owner <= pickWinner(REQ, m_ptr);
            m_len   <= getLen(LEN, pickWinner(REQ, m_ptr));
            m_count <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Every falling edge the DUT must agree with the model and the invariants.
    always @(negedge CLK) begin
        if (!RST) begin
            checkOutput("model GNT", 32'(GNT), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            checkOutput("model DONE", 32'(DONE), (m_fin >= 0) ? (32'd1 << m_fin) : 32'd0);
            checkOutput("model Q", 32'(Q), m_count);
            checkOutput("model BUSY", 32'(BUSY), (m_owner >= 0) ? 32'd1 : 32'd0);
            checkOutput("GNT onehot0", 32'($onehot0(GNT)), 32'd1);
            checkOutput("DONE onehot0", 32'($onehot0(DONE)), 32'd1);
            checkOutput("GNT and DONE overlap", 32'(GNT & DONE), 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req,
                                 input logic [NREQ*WIDTH-1:0] len);
        REQ = req;
        LEN = len;
    endtask

    task automatic pulseReset(input string tag);
        RST = 1'b1;
        #1;
        checkOutput({tag, " reset GNT"}, 32'(GNT), 32'd0);
        checkOutput({tag, " reset DONE"}, 32'(DONE), 32'd0);
        checkOutput({tag, " reset Q"}, 32'(Q), 32'd0);
        checkOutput({tag, " reset BUSY"}, 32'(BUSY), 32'd0);
        RST = 1'b0;
    endtask

    logic [NREQ-1:0] order [5];

    initial begin
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        pulseReset("t0");

        // Test 1: single requester, LEN=3
        applyStimulus(4'b0001, 16'h0003);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t1 GNT", 32'(GNT), 32'h1);
            checkOutput("t1 Q", 32'(Q), i);
        end
        tick();
        checkOutput("t1 DONE", 32'(DONE), 32'h1);
        checkOutput("t1 GNT off", 32'(GNT), 32'h0);
        checkOutput("t1 Q hold", 32'(Q), 32'h3);
        applyStimulus(4'b0000, 16'h0003);
        tick();
        checkOutput("t1 DONE off", 32'(DONE), 32'h0);
        checkOutput("t1 Q clear", 32'(Q), 32'h0);
        tick();
        checkOutput("t1 idle BUSY", 32'(BUSY), 32'h0);

        // Test 2: everyone requesting, round-robin order from PTR=0
        pulseReset("t2");
        applyStimulus(4'b1111, 16'h1111);
        for (int g = 0; g < 5; g++) begin
            tick();
            checkOutput("t2 GNT first", 32'(GNT), 32'(order[g]));
            checkOutput("t2 Q first", 32'(Q), 32'h0);
            tick();
            checkOutput("t2 GNT second", 32'(GNT), 32'(order[g]));
            checkOutput("t2 Q second", 32'(Q), 32'h1);
            tick();
            checkOutput("t2 DONE", 32'(DONE), 32'(order[g]));
            checkOutput("t2 gap1 GNT", 32'(GNT), 32'h0);
            tick();
            checkOutput("t2 gap2 GNT", 32'(GNT), 32'h0);
            checkOutput("t2 gap2 DONE", 32'(DONE), 32'h0);
        end
        applyStimulus(4'b0000, 16'h1111);
        tick();

        // Test 3a: LEN=0 gives a one-cycle run
        applyStimulus(4'b0100, 16'h0000);
        tick();
        checkOutput("t3 short GNT", 32'(GNT), 32'h4);
        checkOutput("t3 short Q", 32'(Q), 32'h0);
        tick();
        checkOutput("t3 short DONE", 32'(DONE), 32'h4);
        checkOutput("t3 short GNT off", 32'(GNT), 32'h0);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        checkOutput("t3 short DONE off", 32'(DONE), 32'h0);

        // Test 3b: full-range LEN=15 stops at all-ones without wrapping
        applyStimulus(4'b0010, 16'h00F0);
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput("t3 long GNT", 32'(GNT), 32'h2);
            checkOutput("t3 long Q", 32'(Q), i);
        end
        tick();
        checkOutput("t3 long DONE", 32'(DONE), 32'h2);
        checkOutput("t3 long Q hold", 32'(Q), 32'hF);
        applyStimulus(4'b0000, 16'h00F0);
        tick();
        checkOutput("t3 long Q clear", 32'(Q), 32'h0);

        // Test 4: abort at Q=4, pending requester 3 granted after one gap cycle
        applyStimulus(4'b0010, 16'h0080);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t4 GNT", 32'(GNT), 32'h2);
            checkOutput("t4 Q", 32'(Q), i);
        end
        applyStimulus(4'b1000, 16'h2080);
        tick();
        checkOutput("t4 abort GNT", 32'(GNT), 32'h0);
        checkOutput("t4 abort DONE", 32'(DONE), 32'h0);
        checkOutput("t4 abort Q", 32'(Q), 32'h0);
        checkOutput("t4 abort BUSY", 32'(BUSY), 32'h0);
        tick();
        checkOutput("t4 next GNT", 32'(GNT), 32'h8);
        checkOutput("t4 next Q", 32'(Q), 32'h0);
        tick();
        tick();
        checkOutput("t4 next Q end", 32'(Q), 32'h2);
        tick();
        checkOutput("t4 next DONE", 32'(DONE), 32'h8);
        applyStimulus(4'b0000, 16'h2080);
        tick();

        // Test 5: move PTR to 1, then reset in the middle of a run
        applyStimulus(4'b0001, 16'h0000);
        tick();
        checkOutput("t5 pre GNT", 32'(GNT), 32'h1);
        tick();
        checkOutput("t5 pre DONE", 32'(DONE), 32'h1);
        applyStimulus(4'b0000, 16'h0000);
        tick();
        applyStimulus(4'b0010, 16'h0090);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t5 run Q", 32'(Q), i);
        end
        applyStimulus(4'b0011, 16'h0011);
        pulseReset("t5");
        tick();
        checkOutput("t5 after reset GNT", 32'(GNT), 32'h1);
        checkOutput("t5 after reset Q", 32'(Q), 32'h0);
        tick();
        checkOutput("t5 after reset Q1", 32'(Q), 32'h1);
        tick();
        checkOutput("t5 after reset DONE", 32'(DONE), 32'h1);
        applyStimulus(4'b0000, 16'h0011);
        tick();

        // Test 6: LEN changes mid-run are ignored
        applyStimulus(4'b0001, 16'h0006);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6 Q early", 32'(Q), i);
        end
        applyStimulus(4'b0001, 16'h0002);
        for (int i = 3; i < 7; i++) begin
            tick();
            checkOutput("t6 GNT late", 32'(GNT), 32'h1);
            checkOutput("t6 Q late", 32'(Q), i);
        end
        tick();
        checkOutput("t6 DONE", 32'(DONE), 32'h1);
        checkOutput("t6 Q hold", 32'(Q), 32'h6);
        applyStimulus(4'b0000, 16'h0002);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one WIDTH-bit up-counter between NREQ requesters.
- Each requester asks for a timed interval of LEN+1 clock cycles.
- The block arbitrates round-robin, loads and runs the shared counter for the winner, then pulses that requester's DONE.
- It sits between the lab's counter datapath and any blocks that need interval timing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter and length width in bits.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  NREQ  level request per requester; held high until DONE, or dropped to abort.
- LEN  input  NREQ*WIDTH  terminal count per requester; LEN[i*WIDTH +: WIDTH] belongs to requester i.
- GNT  output  NREQ  one-hot grant; high for the whole of the owner's run.
- DONE  output  NREQ  one-cycle completion pulse to the owner.
- Q  output  WIDTH  live shared count value.
- BUSY  output  1  high while in RUN.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, PTR=0, sel=0, len_q=0.
  - GNT=0, DONE=0, Q=0, BUSY=0, all immediately.
  - Reset mid-run aborts with no DONE.
- States: IDLE, RUN, FIN.
- IDLE:
  - If REQ==0, stay in IDLE with all outputs 0.
  - Otherwise, at the next edge:
    - sel = first i with REQ[i]=1, searching PTR, PTR+1, ... NREQ-1, 0, ... (rotating priority).
    - GNT[sel]<=1, len_q<=LEN[sel], Q<=0, BUSY<=1, state<=RUN.
- RUN, evaluated each edge with the rules in priority order:
  1. REQ[sel]==0 (abort): GNT<=0, BUSY<=0, Q<=0, PTR<=sel+1 mod NREQ, state<=IDLE. No DONE.
  2. Q==len_q (finish): GNT<=0, BUSY<=0, DONE[sel]<=1, PTR<=sel+1 mod NREQ, state<=FIN. Q holds its value.
  3. Otherwise: Q<=Q+1.
- FIN: at the next edge DONE<=0, Q<=0, state<=IDLE.
- Timing:
  - GNT is high for exactly len_q+1 cycles.
  - Q steps 0,1,...,len_q.
  - DONE rises on the edge after Q==len_q is first seen.
- Gaps: at least 2 cycles between a DONE edge and the next GNT (FIN then IDLE). An abort gives a 1-cycle gap.
- LEN is sampled only on the grant edge; later changes to LEN[sel] are ignored.
- Width and wrap:
  - len_q=0 gives a one-cycle run.
  - len_q=2^WIDTH-1 ends at Q=all-ones.
  - Q never wraps, because the finish check precedes the increment.
- Requests from non-owners during RUN/FIN are ignored and never pre-empt the owner.
- A requester that holds REQ after its DONE is re-granted only if no other requester is pending at or after the advanced PTR.
- Invariants:
  - GNT is always one-hot or zero.
  - DONE is always one-hot or zero.
  - DONE and GNT are never both high.

Test Plan:
1. Reset, then REQ=0001, LEN[0]=3:
   - GNT=0001 for 4 cycles, Q=0,1,2,3.
   - DONE=0001 for one cycle, then Q=0.
   - Drop REQ after DONE; block returns to IDLE.
2. REQ=1111 held throughout, all LEN=1:
   - Grants in order 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts 2 cycles, with 2-cycle gaps between grants.
3. LEN[2]=0, REQ=0100: GNT 1 cycle with Q=0, then DONE=0100. Also run LEN[1]=15 (WIDTH=4): Q reaches 15, DONE fires, and Q never reads 0 after 15 within the run.
4. Abort: REQ=0010, LEN=8, drop REQ[1] when Q=4:
   - GNT clears on the next edge and no DONE appears.
   - A pending REQ[3] is granted next.
5. Assert RST asynchronously mid-run at Q=5:
   - All outputs go 0 before the next edge.
   - After release, REQ=0011 grants requester 0 first, since PTR=0.
6. Change LEN[0] from 6 to 2 while requester 0 runs: the run still ends at Q=6.
